// File: rtl/ca_line_scanout_if.sv
// Generator-side row write bus plus the start request back to the generator.
// The generator drives the master side; the scan-out consumes it via the slave side.
interface ca_line_scanout_if #(
  parameter int AW = 8
);
  logic          write;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          start;

  modport master (output write, output waddr, output wdata, input start);
  modport slave  (input write, input waddr, input wdata, output start);
endinterface

// File: rtl/ca_line_scanout.sv
// Ping-pong line buffer between the CA row generator and the pixel timing stage.
// The generator fills the back bank word by word. The front bank is serialised MSB-first
// as a 1-bit pixel stream on each line. A swap is only honoured once a whole row has landed.
module ca_line_scanout #(
  parameter int WORDS = 160,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  ca_line_scanout_if.slave gen,
  input  logic             line_start,
  input  logic             active,
  input  logic             swap,
  output logic             pixel,
  output logic             late
);

  localparam logic [AW:0] WORDS_W = (AW+1)'(WORDS);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_RUN
  } rd_state_t;

  // Both banks live in one array. The bank select is the top address bit,
  // so a word address never crosses into the other bank.
  logic [15:0] mem [0:(2**(AW+1))-1];
  logic [15:0] rd_data_reg;
  logic        rd_en;
  logic [AW-1:0] rd_word;

  logic        bank_sel_reg;
  logic [AW:0] wr_count_reg;
  logic        filled_reg;
  logic        front_valid_reg;
  logic        start_reg;
  logic        late_reg;
  logic        prime_reg;
  logic        wr_ok;

  rd_state_t   rd_state_reg, rd_state_next;
  logic [15:0] shreg_reg, shreg_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [AW:0] pf_idx_reg, pf_idx_next;   // index of the word sitting in rd_data_reg
  logic [AW:0] pf_idx_inc;
  logic        pixel_reg;

  // Writes beyond the row are dropped entirely, including from the fill count.
  assign wr_ok      = gen.write && ({1'b0, gen.waddr} < WORDS_W);
  assign pf_idx_inc = pf_idx_reg + ONE_W;

  // Line buffer RAM: generator writes into the back bank, registered read from the front bank.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[{~bank_sel_reg, gen.waddr}] <= gen.wdata;
    end
    if (rd_en) begin
      rd_data_reg <= mem[{bank_sel_reg, rd_word}];
    end
  end

  // Bank ownership, fill tracking and the start/late handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_reg    <= 1'b0;
      wr_count_reg    <= '0;
      filled_reg      <= 1'b0;
      front_valid_reg <= 1'b0;
      start_reg       <= 1'b0;
      late_reg        <= 1'b0;
      prime_reg       <= 1'b1;
    end else begin
      // prime_reg turns the first post-reset cycle into one generator request
      prime_reg <= 1'b0;
      start_reg <= prime_reg | (swap & filled_reg);
      late_reg  <= swap & ~filled_reg;
      if (swap && filled_reg) begin
        // a write coinciding with a taken swap is deliberately not counted
        bank_sel_reg    <= ~bank_sel_reg;
        wr_count_reg    <= '0;
        filled_reg      <= 1'b0;
        front_valid_reg <= 1'b1;
      end else if (wr_ok && (wr_count_reg != WORDS_W)) begin
        wr_count_reg <= wr_count_reg + ONE_W;
        filled_reg   <= ((wr_count_reg + ONE_W) == WORDS_W);
      end
    end
  end

  // Read sequencer state and shifter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      shreg_reg    <= '0;
      bit_cnt_reg  <= '0;
      pf_idx_reg   <= '0;
      pixel_reg    <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      shreg_reg    <= shreg_next;
      bit_cnt_reg  <= bit_cnt_next;
      pf_idx_reg   <= pf_idx_next;
      pixel_reg    <= active & front_valid_reg & shreg_reg[15];
    end
  end

  // Read sequencer: line_start fetches word 0. LOAD moves it into the shifter and prefetches word 1.
  // RUN shifts on active and reloads after 16 shifts. Zeros follow once the row is exhausted.
  always_comb begin
    rd_state_next = rd_state_reg;
    shreg_next    = shreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    pf_idx_next   = pf_idx_reg;
    rd_en         = 1'b0;
    rd_word       = '0;
    if (line_start) begin
      rd_state_next = RD_LOAD;
      rd_en         = 1'b1;
      rd_word       = '0;
      bit_cnt_next  = '0;
      pf_idx_next   = '0;
    end else begin
      case (rd_state_reg)
        RD_LOAD: begin
          shreg_next    = rd_data_reg;
          bit_cnt_next  = '0;
          pf_idx_next   = ONE_W;
          rd_state_next = RD_RUN;
          if (WORDS > 1) begin
            rd_en   = 1'b1;
            rd_word = AW'(1);
          end
        end
        RD_RUN: begin
          if (active) begin
            if (bit_cnt_reg == 4'd15) begin
              bit_cnt_next = '0;
              if (pf_idx_reg < WORDS_W) begin
                shreg_next  = rd_data_reg;
                pf_idx_next = pf_idx_inc;
                if (pf_idx_inc < WORDS_W) begin
                  rd_en   = 1'b1;
                  rd_word = pf_idx_inc[AW-1:0];
                end
              end else begin
                shreg_next = '0;
              end
            end else begin
              shreg_next   = {shreg_reg[14:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gen.start = start_reg;
  assign pixel     = pixel_reg;
  assign late      = late_reg;

endmodule

// File: tb/tb_ca_line_scanout.sv
// Directed bench for ca_line_scanout: reset priming, full/partial row fills, bank swaps,
// out-of-range writes, active gaps, over-long lines and mid-operation reset.
module tb_ca_line_scanout;

  localparam int WORDS = 160;

  logic clk = 1'b0;
  logic rst;
  logic line_start;
  logic active;
  logic swap;
  logic pixel;
  logic late;

  ca_line_scanout_if #(.AW(8)) gen_if ();

  ca_line_scanout #(.WORDS(WORDS), .AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .gen        (gen_if),
    .line_start (line_start),
    .active     (active),
    .swap       (swap),
    .pixel      (pixel),
    .late       (late)
  );

  always #5 clk = ~clk;

  // Reference model of the buffer as seen from outside
  logic [15:0] bank_m [2][WORDS];
  int sel_m;
  int fv_m;
  int cnt_m;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int row, input int k);
    logic [15:0] w;
    case (row)
      0:       w = 16'h8000 >> (k % 16);
      1:       w = 16'(k * 16'h1357) ^ 16'hA5C3;
      2:       w = {k[7:0], ~k[7:0]};
      default: w = 16'(k * 31 + 7) ^ 16'h3C3C;
    endcase
    return w;
  endfunction

  function automatic logic exp_pix(input int p);
    int w;
    logic [15:0] word;
    w = p / 16;
    if (fv_m == 0 || w >= WORDS) return 1'b0;
    word = bank_m[sel_m][w];
    return word[15 - (p % 16)];
  endfunction

  task automatic write_word(input int addr, input logic [15:0] data);
    gen_if.write = 1'b1;
    gen_if.waddr = addr[7:0];
    gen_if.wdata = data;
    tick();
    gen_if.write = 1'b0;
    if (addr < WORDS) begin
      bank_m[1 - sel_m][addr] = data;
      if (cnt_m < WORDS) cnt_m++;
    end
  endtask

  task automatic write_row(input int row, input int n);
    for (int k = 0; k < n; k++) write_word(k, pat(row, k));
    $display("row %0d: wrote %0d words", row, n);
  endtask

  task automatic do_swap(input bit taken, input string tag);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check_val({tag, "_start"}, gen_if.start, taken);
    check_val({tag, "_late"}, late, !taken);
    if (taken) begin
      sel_m = 1 - sel_m;
      fv_m  = 1;
      cnt_m = 0;
    end
    tick();
    check_val({tag, "_start_end"}, gen_if.start, 0);
    check_val({tag, "_late_end"}, late, 0);
    $display("swap %s: taken=%0d", tag, taken);
  endtask

  task automatic scan_line(input int n_act, input int gap_at, input int gap_len,
                           input string tag, output int ones);
    ones = 0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    for (int p = 0; p < n_act; p++) begin
      if (p == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          active = 1'b0;
          tick();
          check_val({tag, "_gap"}, pixel, 0);
        end
      end
      active = 1'b1;
      tick();
      check_val(tag, pixel, exp_pix(p));
      if (pixel === 1'b1) ones++;
    end
    active = 1'b0;
    tick();
    check_val({tag, "_idle"}, pixel, 0);
    $display("line %s: %0d active cycles, %0d lit", tag, n_act, ones);
  endtask

  initial begin
    int ones;
    rst = 1'b1;
    line_start = 1'b0;
    active = 1'b0;
    swap = 1'b0;
    gen_if.write = 1'b0;
    gen_if.waddr = '0;
    gen_if.wdata = '0;
    sel_m = 0;
    fv_m = 0;
    cnt_m = 0;

    // Reset and priming pulse
    tick(); tick(); tick();
    check_val("rst_start", gen_if.start, 0);
    check_val("rst_pixel", pixel, 0);
    check_val("rst_late", late, 0);
    rst = 1'b0;
    tick();
    check_val("prime_start", gen_if.start, 1);
    tick();
    check_val("prime_start_once", gen_if.start, 0);
    tick();
    check_val("prime_start_quiet", gen_if.start, 0);
    $display("reset: prime pulse checked");

    // No valid front yet: dark line
    scan_line(40, -1, 0, "dark0", ones);
    check_val("dark0_ones", ones, 0);

    // Full diagonal row: one lit pixel per word at 16k + k%16
    write_row(0, WORDS);
    do_swap(1'b1, "swapA");
    scan_line(16 * WORDS, -1, 0, "rowA", ones);
    check_val("rowA_ones", ones, 160);

    // Incomplete row: late, front stays row A; completing it lets the swap through
    write_row(1, WORDS - 1);
    do_swap(1'b0, "swapB_late");
    scan_line(200, -1, 0, "rowA_again", ones);
    write_word(WORDS - 1, pat(1, WORDS - 1));
    do_swap(1'b1, "swapB");
    // 5-cycle active gap in word 3, then run 40 pixels beyond the row
    scan_line(16 * WORDS + 40, 53, 5, "rowB", ones);

    // Out-of-range writes neither count nor disturb the front bank
    write_word(160, 16'hFFFF);
    write_word(255, 16'hFFFF);
    scan_line(64, -1, 0, "rowB_after_oob", ones);
    write_row(2, WORDS - 1);
    do_swap(1'b0, "swapC_late");
    write_word(WORDS - 1, pat(2, WORDS - 1));
    do_swap(1'b1, "swapC");
    scan_line(300, -1, 0, "rowC", ones);

    // Reset mid-line and mid-row-write
    for (int k = 0; k < 80; k++) write_word(k, pat(3, k));
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    for (int p = 0; p < 30; p++) begin
      active = 1'b1;
      gen_if.write = 1'b1;
      gen_if.waddr = 8'(80 + p);
      gen_if.wdata = pat(3, 80 + p);
      tick();
      check_val("rowC_pre_rst", pixel, exp_pix(p));
    end
    rst = 1'b1;
    active = 1'b0;
    gen_if.write = 1'b0;
    tick();
    check_val("midrst_pixel", pixel, 0);
    check_val("midrst_start", gen_if.start, 0);
    check_val("midrst_late", late, 0);
    tick();
    rst = 1'b0;
    sel_m = 0;
    fv_m = 0;
    cnt_m = 0;
    tick();
    check_val("reprime_start", gen_if.start, 1);
    tick();
    check_val("reprime_start_once", gen_if.start, 0);
    $display("reset: mid-line reset checked");
    scan_line(100, -1, 0, "dark1", ones);
    check_val("dark1_ones", ones, 0);
    write_row(3, WORDS);
    do_swap(1'b1, "swapD");
    scan_line(400, -1, 0, "rowD", ones);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
